qupls4_reservation_station: RTL
===============================

// Module: qupls4_reservation_station
// PURPOSE
// - Per-functional-unit reservation station. Sits directly downstream of the instruction dispatcher.
// - Captures dispatched reservation_station_entry_t packets addressed to this unit.
// - Snoops the register write-back buses to wake up pending operands.
// - Issues the oldest fully-ready entry to the functional unit. Returns busy to the dispatcher.
// PARAMETERS
// - FUNCUNIT   4'd0   functional-unit id this station serves; matched against rse_i[k].funcunit
// - NENTRIES   4      station depth (2..8)
// - NWRPORTS   4      number of write-back (wakeup) buses
// PORTS
// - clk          in   1               clock; all state updates on posedge
// - rst          in   1               synchronous, active-high reset
// - rse_i        in   4 x rse_t       dispatcher output packets (Qupls4_pkg::reservation_station_entry_t)
// - rse_v        in   4               per-slot valid (dispatcher rob_dispatched_v)
// - stomp        in   ROB_ENTRIES     squash mask, indexed by entry rndx
// - wr_v         in   NWRPORTS        write-back valid
// - wr_preg      in   NWRPORTS x 9    write-back physical register
// - wr_data      in   NWRPORTS x 64   write-back value
// - fu_ready     in   1               functional unit can accept an op this cycle
// - busy         out  1               to dispatcher busy[FUNCUNIT]; registered
// - issue_v      out  1               issue valid; registered
// - issue_rse    out  rse_t           issued entry with argA..argD resolved
// - count        out  4               occupied entries; registered
// BEHAVIOUR
// - Reset: all entries EMPTY; busy=0, issue_v=0, issue_rse=0, count=0. Reset mid-operation discards everything, including an in-flight issue.
// - Accept: slot k accepted when rse_v[k] && rse_i[k].funcunit==FUNCUNIT && !stomp[rse_i[k].rndx].
//   - At most one slot matches per cycle. If several match, take the lowest k.
//   - The entry is written to the lowest-index EMPTY entry with an age stamp greater than every resident entry.
//   - Earliest issue is the cycle after accept.
// - Per-entry states:
//   - EMPTY -> WAIT on accept with any argX_v==0.
//   - EMPTY -> READY on accept when all four args are valid after same-cycle wakeup.
//   - WAIT -> READY when the last invalid operand is woken.
//   - READY -> EMPTY on issue.
//   - Any state -> EMPTY on stomp[rndx].
// - Wakeup: for each invalid argX, if wr_v[p] && wr_preg[p]==argX[8:0], set argX=wr_data[p] and argX_v=1.
//   - Applies to resident entries and to the entry being accepted in the same cycle.
//   - Multiple matching ports: the lowest p wins.
// - Issue select: oldest (smallest age) READY entry with fu_ready=1.
//   - issue_v/issue_rse are registered next edge, so latency is 1 cycle from READY.
//   - issue_v=0 when nothing is selected.
//   - Issue and accept may target the same physical entry in one cycle: issue frees it, accept refills it.
// - Stomp: an entry stomped in the same cycle it would be selected is not issued.
// - Age: 3-bit wrap-safe ordering via relative age matrix (NENTRIES x NENTRIES); no counter overflow.
// - busy = registered (free entries after this cycle <= 1). Covers the dispatcher's one-cycle busy sample delay.
//   - An accept arriving when no entry is free is dropped and flags an assertion.
// - count = occupied entries after this cycle's accept/issue/stomp.
// CONFIGURATION
// - QUPLS4_RS_BYPASS_EN defined:
//   - A WAIT entry whose final operands all match wr buses this cycle is selectable this cycle.
//   - issue_rse carries the wr_data values, so wakeup-to-issue is 1 cycle.
//   - Age priority still applies across READY and bypassed entries.
// - QUPLS4_RS_BYPASS_EN undefined:
//   - Only READY entries are selectable; wakeup-to-issue is 2 cycles.
// TESTING
// - Reset, then rse_v=4'b0001 with FUNCUNIT match and all args valid, fu_ready=1 -> issue_v=1 two edges later; busy=0; count 1->0.
// - Entry with argB_v=0, argB[8:0]=9'h05; wr_v[2]=1, wr_preg[2]=9'h05, wr_data[2]=64'hDEAD -> issue_rse.argB=64'hDEAD, argB_v=1.
//   - Issue one cycle later with the macro defined, two cycles later without.
// - Fill 4 entries with fu_ready=0 -> busy=1 after the 3rd accept; count=4.
//   - Then fu_ready=1 -> entries issue in accept order.
// - Two READY entries, older accepted first -> older issues first, even when the younger occupies a lower index.
// - stomp[rndx=7] asserted while entry rndx=7 is READY and selected -> no issue; count decrements.
// - rst pulsed while 3 entries are pending and issue_v=1 -> next cycle issue_v=0, count=0, busy=0.
//   - A subsequent wakeup causes no issue.

Source files
------------

// File: rtl/qupls4_reservation_station.sv
// qupls4_reservation_station: per-FU reservation station with operand wakeup and oldest-ready issue.
// Optional QUPLS4_RS_BYPASS_EN lets a waiting entry issue in the same cycle its last operands arrive.
package Qupls4_pkg;
    parameter int ROB_ENTRIES = 16;
    typedef struct packed {
        logic [31:0] op;
        logic [3:0]  funcunit;
        logic [3:0]  rndx;
        logic        argA_v;
        logic [63:0] argA;
        logic        argB_v;
        logic [63:0] argB;
        logic        argC_v;
        logic [63:0] argC;
        logic        argD_v;
        logic [63:0] argD;
    } reservation_station_entry_t;
    typedef reservation_station_entry_t rse_t;
endpackage

module qupls4_reservation_station import Qupls4_pkg::*; #(
    parameter logic [3:0] FUNCUNIT = 4'd0,
    parameter int NENTRIES = 4,
    parameter int NWRPORTS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  rse_t                   rse_i [4],
    input  logic [3:0]             rse_v,
    input  logic [ROB_ENTRIES-1:0] stomp,
    input  logic [NWRPORTS-1:0]    wr_v,
    input  logic [8:0]             wr_preg [NWRPORTS],
    input  logic [63:0]            wr_data [NWRPORTS],
    input  logic                   fu_ready,
    output logic                   busy,
    output logic                   issue_v,
    output rse_t                   issue_rse,
    output logic [3:0]             count
);
    typedef enum logic [1:0] {EMPTY, WAIT, READY} state_t;

    state_t st [NENTRIES];
    state_t st_n [NENTRIES];
    rse_t ent [NENTRIES];
    rse_t ent_n [NENTRIES];
    rse_t woke [NENTRIES];
    logic [NENTRIES-1:0] older [NENTRIES];
    logic [NENTRIES-1:0] kill, cand, sel, fsel;
    logic acc_hit, found;
    rse_t acc_e, sel_e;
    logic [3:0] cnt_n;

    // Descending port scan so the lowest matching port is applied last and wins.
    function automatic rse_t wake(input rse_t e);
        wake = e;
        for (int p = NWRPORTS - 1; p >= 0; p--) begin
            if (wr_v[p] && !e.argA_v && wr_preg[p] == e.argA[8:0]) begin wake.argA = wr_data[p]; wake.argA_v = 1'b1; end
            if (wr_v[p] && !e.argB_v && wr_preg[p] == e.argB[8:0]) begin wake.argB = wr_data[p]; wake.argB_v = 1'b1; end
            if (wr_v[p] && !e.argC_v && wr_preg[p] == e.argC[8:0]) begin wake.argC = wr_data[p]; wake.argC_v = 1'b1; end
            if (wr_v[p] && !e.argD_v && wr_preg[p] == e.argD[8:0]) begin wake.argD = wr_data[p]; wake.argD_v = 1'b1; end
        end
    endfunction

    function automatic logic all_v(input rse_t e);
        return e.argA_v && e.argB_v && e.argC_v && e.argD_v;
    endfunction

    always_comb begin
        acc_hit = 1'b0;
        acc_e = '0;
        kill = '0;
        cand = '0;
        for (int k = 3; k >= 0; k--)
            if (rse_v[k] && rse_i[k].funcunit == FUNCUNIT && !stomp[rse_i[k].rndx]) begin
                acc_hit = 1'b1;
                acc_e = wake(rse_i[k]);
            end
        for (int i = 0; i < NENTRIES; i++) begin
            woke[i] = wake(ent[i]);
            kill[i] = st[i] != EMPTY && stomp[ent[i].rndx];
`ifdef QUPLS4_RS_BYPASS_EN
            cand[i] = fu_ready && !kill[i] && (st[i] == READY || (st[i] == WAIT && all_v(woke[i])));
`else
            cand[i] = fu_ready && !kill[i] && st[i] == READY;
`endif
        end
        // older[j][i]: entry j was accepted before entry i.
        sel = cand;
        for (int i = 0; i < NENTRIES; i++)
            for (int j = 0; j < NENTRIES; j++)
                if (j != i && cand[j] && older[j][i]) sel[i] = 1'b0;
        sel_e = '0;
        for (int i = 0; i < NENTRIES; i++)
            if (sel[i]) sel_e = woke[i];
        found = 1'b0;
        fsel = '0;
        for (int i = 0; i < NENTRIES; i++)
            if ((st[i] == EMPTY || kill[i] || sel[i]) && !found) begin
                fsel[i] = 1'b1;
                found = 1'b1;
            end
        cnt_n = '0;
        for (int i = 0; i < NENTRIES; i++) begin
            st_n[i] = (st[i] == EMPTY || kill[i] || sel[i]) ? EMPTY : all_v(woke[i]) ? READY : WAIT;
            ent_n[i] = woke[i];
            if (acc_hit && fsel[i]) begin
                st_n[i] = all_v(acc_e) ? READY : WAIT;
                ent_n[i] = acc_e;
            end
            cnt_n = cnt_n + {3'b0, st_n[i] != EMPTY};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NENTRIES; i++) begin
                st[i] <= EMPTY;
                ent[i] <= '0;
                older[i] <= '0;
            end
            busy <= 1'b0;
            issue_v <= 1'b0;
            issue_rse <= '0;
            count <= '0;
        end else begin
            assert (!(acc_hit && !found));
            for (int i = 0; i < NENTRIES; i++) begin
                st[i] <= st_n[i];
                ent[i] <= ent_n[i];
            end
            for (int i = 0; i < NENTRIES; i++)
                for (int j = 0; j < NENTRIES; j++)
                    if (acc_hit && fsel[j]) begin
                        older[i][j] <= (i != j);
                        older[j][i] <= 1'b0;
                    end
            issue_v <= |sel;
            if (|sel) issue_rse <= sel_e;
            count <= cnt_n;
            busy <= cnt_n >= 4'(NENTRIES - 1);
        end
    end
endmodule
